// File: rtl/transpose_buffer_8x8.sv
// 8x8 ping-pong transpose buffer between the row and column passes of a 2-D DCT.
// Rows are written into one bank while the other bank is drained column by
// column. Bank status and pointers are registered, so in_ready and out_valid
// never depend on same-cycle handshakes.
module transpose_buffer_8x8 #(
  parameter int W = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0][W-1:0]   in_row,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0][W-1:0]   out_col,
  output logic                out_last
);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_st_e;

  bank_st_e       st_q [2];
  bank_st_e       st_d [2];
  logic           wr_bank_q, wr_bank_d;
  logic           rd_bank_q, rd_bank_d;
  logic [2:0]     wr_row_q, wr_row_d;
  logic [2:0]     rd_col_q, rd_col_d;
  logic [W-1:0]   mem_q [2][8][8];

  logic           wr_fire_s;
  logic           rd_fire_s;

  // Handshake qualifiers come from registered bank status only.
  assign in_ready  = (st_q[wr_bank_q] != BANK_FULL);
  assign out_valid = (st_q[rd_bank_q] == BANK_FULL);
  assign wr_fire_s = in_valid & in_ready;
  assign rd_fire_s = out_valid & out_ready;

  // Next-state for bank status and fill/drain pointers.
  // A write can never target a FULL bank and a drain only touches a FULL bank,
  // so the two updates always address different banks.
  always_comb begin
    st_d[0]   = st_q[0];
    st_d[1]   = st_q[1];
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_row_d  = wr_row_q;
    rd_col_d  = rd_col_q;

    if (wr_fire_s) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == 3'd7) begin
        st_d[wr_bank_q] = BANK_FULL;
        wr_bank_d       = ~wr_bank_q;
      end else begin
        st_d[wr_bank_q] = BANK_FILLING;
      end
    end else begin
      wr_row_d = wr_row_q;
    end

    if (rd_fire_s) begin
      rd_col_d = rd_col_q + 3'd1;
      if (rd_col_q == 3'd7) begin
        st_d[rd_bank_q] = BANK_EMPTY;
        rd_bank_d       = ~rd_bank_q;
      end else begin
        rd_bank_d = rd_bank_q;
      end
    end else begin
      rd_col_d = rd_col_q;
    end
  end

  // Control state register; reset wins over any same-edge transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q[0]   <= BANK_EMPTY;
      st_q[1]   <= BANK_EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_row_q  <= 3'd0;
      rd_col_q  <= 3'd0;
    end else begin
      st_q[0]   <= st_d[0];
      st_q[1]   <= st_d[1];
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_row_q  <= wr_row_d;
      rd_col_q  <= rd_col_d;
    end
  end

  // Coefficient storage; contents survive reset but are hidden by bank status.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire_s) begin
      for (int j = 0; j < 8; j++) begin
        mem_q[wr_bank_q][wr_row_q][j] <= in_row[j];
      end
    end
  end

  // Column read mux: element k is row k of the current column, zero when idle.
  always_comb begin
    out_col = '0;
    if (out_valid) begin
      for (int k = 0; k < 8; k++) begin
        out_col[k] = mem_q[rd_bank_q][k][rd_col_q];
      end
    end else begin
      out_col = '0;
    end
  end

  // Last-beat flag marks column 7 of each block.
  always_comb begin
    out_last = 1'b0;
    if (out_valid && (rd_col_q == 3'd7)) begin
      out_last = 1'b1;
    end else begin
      out_last = 1'b0;
    end
  end

endmodule

// File: tb/tb_transpose_buffer_8x8.sv
// Self-checking bench for transpose_buffer_8x8. A queue of completed 8x8
// blocks plus a partial-row buffer stands in for the design.
module tb_transpose_buffer_8x8;

  localparam int W = 18;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [7:0][W-1:0]  in_row;
  logic               out_valid;
  logic               out_ready;
  logic [7:0][W-1:0]  out_col;
  logic               out_last;

  transpose_buffer_8x8 #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: blocks stored row-major as 64 words.
  typedef logic [W-1:0] blk_t [64];
  blk_t mq[$];
  blk_t part;
  int   prow;
  int   mcol;

  int n_pass;
  int n_total;

  function automatic logic m_ready();
    return (mq.size() < 2);
  endfunction

  function automatic logic m_valid();
    return (mq.size() > 0);
  endfunction

  function automatic logic m_last();
    return (mq.size() > 0) && (mcol == 7);
  endfunction

  function automatic logic [7:0][W-1:0] m_col();
    logic [7:0][W-1:0] v;
    v = '0;
    if (mq.size() > 0) begin
      for (int k = 0; k < 8; k++) v[k] = mq[0][k*8 + mcol];
    end
    return v;
  endfunction

  // Advance one clock and update the model from the inputs that were presented.
  task automatic tick();
    logic rd;
    logic wr;
    rd = m_valid() && out_ready;
    wr = in_valid && m_ready();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      prow = 0;
      mcol = 0;
    end else begin
      if (rd) begin
        mcol++;
        if (mcol == 8) begin
          mcol = 0;
          void'(mq.pop_front());
        end
      end
      if (wr) begin
        for (int j = 0; j < 8; j++) part[prow*8 + j] = in_row[j];
        prow++;
        if (prow == 8) begin
          mq.push_back(part);
          prow = 0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_row();
    for (int j = 0; j < 8; j++) in_row[j] = W'($urandom);
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    out_ready = 1'b1;
    rand_row();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_col !== '0) $display("FAIL reset_out_col got %h want 0", out_col); else n_pass++;
    n_total++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", out_last); else n_pass++;
  endtask

  task automatic test_single_block();
    logic [7:0][W-1:0] e;
    do_reset();
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      in_valid = 1'b1;
      for (int j = 0; j < 8; j++) in_row[j] = W'(8*r + j);
      n_total++; if (in_ready !== 1'b1) $display("FAIL single_in_ready row %0d got %b want 1", r, in_ready); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL single_early_valid row %0d got %b want 0", r, out_valid); else n_pass++;
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 8; k++) e[k] = W'(8*k + c);
      n_total++; if (out_valid !== 1'b1) $display("FAIL single_valid col %0d got %b want 1", c, out_valid); else n_pass++;
      n_total++; if (out_col !== e) $display("FAIL single_col col %0d got %h want %h", c, out_col, e); else n_pass++;
      n_total++; if (out_last !== (c == 7)) $display("FAIL single_last col %0d got %b want %b", c, out_last, (c == 7)); else n_pass++;
      tick();
    end
    n_total++; if (out_valid !== 1'b0) $display("FAIL single_done_valid got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cols;
    int first;
    do_reset();
    out_ready = 1'b1;
    cols = 0;
    first = -1;
    for (int i = 0; i < 36; i++) begin
      in_valid = (i < 24);
      rand_row();
      if (i >= 8 && i < 24) begin
        n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready cycle %0d got %b want 1", i, in_ready); else n_pass++;
      end
      n_total++; if (out_valid !== m_valid()) $display("FAIL b2b_valid cycle %0d got %b want %b", i, out_valid, m_valid()); else n_pass++;
      n_total++; if (out_col !== m_col()) $display("FAIL b2b_col cycle %0d got %h want %h", i, out_col, m_col()); else n_pass++;
      n_total++; if (out_last !== m_last()) $display("FAIL b2b_last cycle %0d got %b want %b", i, out_last, m_last()); else n_pass++;
      if (out_valid === 1'b1) begin
        if (first < 0) first = i;
        cols++;
      end
      tick();
    end
    n_total++; if (cols !== 24) $display("FAIL b2b_col_count got %0d want 24", cols); else n_pass++;
    n_total++; if (first !== 8) $display("FAIL b2b_first_col_cycle got %0d want 8", first); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      rand_row();
      n_total++; if (in_ready !== (i < 16)) $display("FAIL bp_in_ready row %0d got %b want %b", i, in_ready, (i < 16)); else n_pass++;
      if (i < 16) tick();
    end
    n_total++; if (out_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", out_valid); else n_pass++;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      n_total++; if (in_ready !== 1'b0) $display("FAIL bp_held_off col %0d got %b want 0", c, in_ready); else n_pass++;
      n_total++; if (out_col !== m_col()) $display("FAIL bp_col col %0d got %h want %h", c, out_col, m_col()); else n_pass++;
      tick();
    end
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_return got %b want 1", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      n_total++; if (out_valid !== m_valid()) $display("FAIL bp_drain_valid beat %0d got %b want %b", c, out_valid, m_valid()); else n_pass++;
      n_total++; if (out_col !== m_col()) $display("FAIL bp_drain_col beat %0d got %h want %h", c, out_col, m_col()); else n_pass++;
      tick();
    end
  endtask

  task automatic test_stall_random();
    logic              prev_stall;
    logic [7:0][W-1:0] prev_col;
    logic              prev_last;
    do_reset();
    prev_stall = 1'b0;
    prev_col = '0;
    prev_last = 1'b0;
    for (int i = 0; i < 420; i++) begin
      in_valid = (i < 400) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
      out_ready = (i < 400) ? 1'($urandom_range(0, 1)) : 1'b1;
      rand_row();
      n_total++; if (in_ready !== m_ready()) $display("FAIL stall_in_ready cycle %0d got %b want %b", i, in_ready, m_ready()); else n_pass++;
      n_total++; if (out_valid !== m_valid()) $display("FAIL stall_valid cycle %0d got %b want %b", i, out_valid, m_valid()); else n_pass++;
      n_total++; if (out_col !== m_col()) $display("FAIL stall_col cycle %0d got %h want %h", i, out_col, m_col()); else n_pass++;
      n_total++; if (out_last !== m_last()) $display("FAIL stall_last cycle %0d got %b want %b", i, out_last, m_last()); else n_pass++;
      if (prev_stall) begin
        n_total++; if (out_col !== prev_col || out_last !== prev_last) $display("FAIL stall_stable cycle %0d got %h/%b want %h/%b", i, out_col, out_last, prev_col, prev_last); else n_pass++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_col = out_col;
      prev_last = out_last;
      tick();
    end
  endtask

  task automatic test_extremes();
    logic [W-1:0]      pos;
    logic [W-1:0]      neg;
    logic [7:0][W-1:0] e;
    pos = {1'b0, {(W-1){1'b1}}};
    neg = {1'b1, {(W-1){1'b0}}};
    do_reset();
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      in_valid = 1'b1;
      for (int j = 0; j < 8; j++) in_row[j] = ((r + j) % 2 == 1) ? neg : pos;
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 8; k++) e[k] = ((k + c) % 2 == 1) ? neg : pos;
      n_total++; if (out_col !== e) $display("FAIL extreme_col col %0d got %h want %h", c, out_col, e); else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0][W-1:0] e;
    do_reset();
    out_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      in_valid = 1'b1;
      rand_row();
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rstmid_fill_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rstmid_fill_ready got %b want 1", in_ready); else n_pass++;
    for (int r = 0; r < 8; r++) begin
      in_valid = 1'b1;
      rand_row();
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      n_total++; if (out_col !== m_col()) $display("FAIL rstmid_drain_col col %0d got %h want %h", c, out_col, m_col()); else n_pass++;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rstmid_drain_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rstmid_drain_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_col !== '0) $display("FAIL rstmid_drain_col0 got %h want 0", out_col); else n_pass++;
    for (int r = 0; r < 8; r++) begin
      in_valid = 1'b1;
      for (int j = 0; j < 8; j++) in_row[j] = W'(1000 + 8*r + j);
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 8; k++) e[k] = W'(1000 + 8*k + c);
      n_total++; if (out_col !== e) $display("FAIL rstmid_fresh_col col %0d got %h want %h", c, out_col, e); else n_pass++;
      n_total++; if (out_last !== (c == 7)) $display("FAIL rstmid_fresh_last col %0d got %b want %b", c, out_last, (c == 7)); else n_pass++;
      tick();
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    prow = 0;
    mcol = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_row = '0;
    #2;
    test_reset();
    test_single_block();
    test_back_to_back();
    test_backpressure();
    test_stall_random();
    test_extremes();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/transpose_buffer_8x8.md
TRANSPOSE_BUFFER_8X8 -- requirements
Module: transpose_buffer_8x8

Interface
REQ-001 Parameter: W, default 18, coefficient width in bits; matches the 1-D DCT output width N+10 for N=8.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  in_row holds a valid row of 8 row-pass coefficients.
REQ-005 Port: in_ready  output  1  the block accepts in_row this cycle.
REQ-006 Port: in_row  input  [7:0][W-1:0]  one row, element j = coefficient j, signed.
REQ-007 Port: out_valid  output  1  out_col holds a valid column.
REQ-008 Port: out_ready  input  1  the downstream column-pass DCT accepts out_col this cycle.
REQ-009 Port: out_col  output  [7:0][W-1:0]  one column, element k = row k of that column, signed.
REQ-010 Port: out_last  output  1  high with the column-7 beat of each block.

Function
REQ-011 A row transfer occurs on a rising edge with in_valid=1 and in_ready=1; a column transfer occurs on a rising edge with out_valid=1 and out_ready=1.
REQ-012 Storage is two 8x8 banks of W-bit words (ping-pong); each bank is EMPTY, FILLING or FULL.
REQ-013 A write pointer wr_bank and a 3-bit row counter wr_row select the fill target; a read pointer rd_bank and a 3-bit column counter rd_col select the drain source.
REQ-014 in_ready = 1 iff bank[wr_bank] is not FULL.
REQ-015 Row transfer: bank[wr_bank][wr_row][j] <= in_row[j] for j=0..7, and wr_row increments.
REQ-016 Transfer with wr_row=7: wr_row wraps to 0, bank[wr_bank] becomes FULL, and wr_bank toggles.
REQ-017 out_valid = 1 iff bank[rd_bank] is FULL; out_valid is derived from registered state only.
REQ-018 out_col[k] = bank[rd_bank][k][rd_col] for k=0..7 while out_valid=1; out_col = 0 while out_valid=0.
REQ-019 out_last = out_valid AND (rd_col = 7).
REQ-020 Column transfer: rd_col increments; at rd_col=7 it wraps to 0, bank[rd_bank] becomes EMPTY, and rd_bank toggles.
REQ-021 Latency: when row 7 of a block transfers on edge t, out_valid is high in the cycle after edge t; column 0 carries that block.
REQ-022 Sustained throughput is 1 row/cycle in and 1 column/cycle out; with out_ready held at 1 there are no bubbles between blocks.
REQ-023 A fill and a drain on different banks in the same cycle both take effect.
REQ-024 A drain completing (bank -> EMPTY) on the same edge as a row write that targets the freed bank takes effect on the next edge; in_ready reflects only registered state.
REQ-025 When both banks are FULL, in_ready=0, and in_row and in_valid are ignored.
REQ-026 out_col and out_last stay stable while out_valid=1 and out_ready=0.
REQ-027 Data are passed bit-exact with no arithmetic, rounding or sign change; the column index order is 0..7.

Reset
REQ-028 On an edge with rst=1: both banks become EMPTY, wr_bank=rd_bank=0, wr_row=rd_col=0; in the following cycle in_ready=1, out_valid=0, out_col=0 and out_last=0.
REQ-029 A reset mid-block discards any partially filled or partially drained block; storage contents are not cleared and are never visible.
REQ-030 rst has priority over simultaneous transfers on the same edge.

Verification
REQ-031 Single block: rows r=0..7 with in_row[j] = 8r+j, out_ready=1 -> out_valid rises in the cycle after row 7; columns c=0..7 give out_col[k] = 8k+c; out_last is high only on c=7.
REQ-032 Back-to-back: 3 blocks with in_valid and out_ready held at 1 -> in_ready is never 0 after the first block; 24 columns appear contiguously, each transposed correctly.
REQ-033 Backpressure: out_ready=0 while 2 blocks are written -> in_ready drops after row 7 of block 2, and a 17th row is held off; after out_ready=1, block 1 drains and in_ready returns 1 in the cycle after its column 7.
REQ-034 Stall stability: out_ready toggled randomly -> out_col is unchanged across every stalled cycle, with no column lost or duplicated.
REQ-035 Signed extremes: rows of -2^(W-1) and 2^(W-1)-1 alternating -> the values emerge bit-exact, transposed.
REQ-036 Reset mid-operation: rst asserted after row 4 of block 1 and again after column 3 of a drain -> the next cycle shows out_valid=0 and in_ready=1; a fresh block then transposes correctly with no stale data.
